ctrl_pipe: RTL and testbench

Pipeline control carrier and hazard unit for the 5-stage core. It accepts the decoded control word and register indices from the ID stage and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers. It also generates load-use stalls, branch flushes and EX-stage forwarding selects, and keeps saturating stall and flush counters. It sits between the opcode decoder and the datapath stage registers, and drives their per-stage enables and muxes.

---
 rtl/ctrl_pipe.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pipe.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM, MEM/WB and generates
// load-use stalls, branch flushes and EX forwarding selects. Build option: FORWARDING_EN.

`ifdef FORWARDING_EN
module ctrl_fwd_sel (
    input  logic       mem_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_rd,
    input  logic [4:0] src,
    output logic [1:0] sel
);
    // EX/MEM is the younger producer, so it wins a double match
    always_comb begin
        sel = 2'b00;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == src)
            sel = 2'b10;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src)
            sel = 2'b01;
    end
endmodule
`endif

module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_mem2reg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic [1:0]       id_aluop,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic [1:0]       ex_aluop,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_mem2reg,
    output logic             wb_regwrite,
    output logic             pc_src,
    output logic             stall,
    output logic             if_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       mem2reg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_t      id_ctrl, ex_ctrl;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mem_mem2reg, mem_regwrite;
    logic [4:0] mem_rd, wb_rd;
    logic       ex_hit, hazard;

    assign id_ctrl = '{branch: id_branch, memread: id_memread, mem2reg: id_mem2reg,
                       memwrite: id_memwrite, alusrc: id_alusrc, regwrite: id_regwrite,
                       aluop: id_aluop};

    assign ex_alusrc = ex_ctrl.alusrc;
    assign ex_branch = ex_ctrl.branch;
    assign ex_aluop  = ex_ctrl.aluop;
    assign pc_src    = ex_ctrl.branch & ex_zero;
    assign if_flush  = pc_src;

    // rs2 is compared for every opcode; harmless over-stall on I-types
    assign ex_hit = (ex_rd != 5'd0) && (ex_rd == id_rs1 || ex_rd == id_rs2);

`ifdef FORWARDING_EN
    logic [1:0][4:0] ex_src;
    logic [1:0][1:0] fwd_sel;

    assign hazard = ex_ctrl.memread & ex_hit;
    assign ex_src = {ex_rs2, ex_rs1};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        ctrl_fwd_sel u_sel (
            .mem_regwrite(mem_regwrite),
            .mem_rd      (mem_rd),
            .wb_regwrite (wb_regwrite),
            .wb_rd       (wb_rd),
            .src         (ex_src[i]),
            .sel         (fwd_sel[i])
        );
    end

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];
`else
    logic mem_hit;
    logic unused_regs;

    // No bypass: any in-flight producer in EX or MEM holds the consumer in ID
    assign mem_hit     = (mem_rd != 5'd0) && (mem_rd == id_rs1 || mem_rd == id_rs2);
    assign hazard      = (ex_ctrl.regwrite & ex_hit) | (mem_regwrite & mem_hit);
    assign fwd_a       = 2'b00;
    assign fwd_b       = 2'b00;
    assign unused_regs = ^{ex_rs1, ex_rs2, wb_rd};
`endif

    // The ID instruction is being squashed, so a hazard on it is moot
    assign stall = hazard & ~pc_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl      <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_mem2reg  <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_mem2reg   <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            if (pc_src || stall) begin
                ex_ctrl <= '0;
                ex_rs1  <= '0;
                ex_rs2  <= '0;
                ex_rd   <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rs1  <= id_rs1;
                ex_rs2  <= id_rs2;
                ex_rd   <= id_rd;
            end

            mem_memread  <= ex_ctrl.memread;
            mem_memwrite <= ex_ctrl.memwrite;
            mem_mem2reg  <= ex_ctrl.mem2reg;
            mem_regwrite <= ex_ctrl.regwrite;
            mem_rd       <= ex_rd;

            wb_mem2reg   <= mem_mem2reg;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;

            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (pc_src && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe; expectations switch on FORWARDING_EN to match the build.
module tb_ctrl_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_branch, id_memread, id_mem2reg, id_memwrite, id_alusrc, id_regwrite;
    logic [1:0] id_aluop;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero;

    logic        ex_alusrc, ex_branch, mem_memread, mem_memwrite, wb_mem2reg, wb_regwrite;
    logic [1:0]  ex_aluop, fwd_a, fwd_b;
    logic        pc_src, stall, if_flush;
    logic [15:0] stall_cnt, flush_cnt;

    logic       s_ex_alusrc, s_ex_branch, s_mem_memread, s_mem_memwrite, s_wb_mem2reg, s_wb_regwrite;
    logic [1:0] s_ex_aluop, s_fwd_a, s_fwd_b;
    logic       s_pc_src, s_stall, s_if_flush;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    ctrl_pipe #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_branch(id_branch), .id_memread(id_memread), .id_mem2reg(id_mem2reg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_zero(ex_zero),
        .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .wb_mem2reg(wb_mem2reg), .wb_regwrite(wb_regwrite),
        .pc_src(pc_src), .stall(stall), .if_flush(if_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy on the same stimulus, used for saturation
    ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .id_branch(id_branch), .id_memread(id_memread), .id_mem2reg(id_mem2reg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_zero(ex_zero),
        .ex_alusrc(s_ex_alusrc), .ex_branch(s_ex_branch), .ex_aluop(s_ex_aluop),
        .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
        .wb_mem2reg(s_wb_mem2reg), .wb_regwrite(s_wb_regwrite),
        .pc_src(s_pc_src), .stall(s_stall), .if_flush(s_if_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic drive(input logic br, input logic mr, input logic m2r, input logic mw,
                         input logic as, input logic rw, input logic [1:0] op,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_branch = br; id_memread = mr; id_mem2reg = m2r; id_memwrite = mw;
        id_alusrc = as; id_regwrite = rw; id_aluop = op;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_zero = 1'b0;
        nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  2'($urandom_range(3)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                  5'($urandom_range(31)));
            ex_zero = 1'($urandom_range(1));
            tick();
        end
        settle();
        checks++;
        if ({ex_alusrc, ex_branch, ex_aluop, mem_memread, mem_memwrite, wb_mem2reg, wb_regwrite,
             pc_src, stall, if_flush, fwd_a, fwd_b} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {ex_alusrc, ex_branch, ex_aluop,
                     mem_memread, mem_memwrite, wb_mem2reg, wb_regwrite, pc_src, stall,
                     if_flush, fwd_a, fwd_b});
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if (s_stall_cnt !== 4'd0 || s_flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters4: got %0d/%0d want 0/0", s_stall_cnt, s_flush_cnt);
        end
        reset = 1'b0;
        nop();
        ex_zero = 1'b0;
    endtask

    task automatic test_pass_through();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd1, 5'd2, 5'd5);
        tick();
        drive(0, 1, 1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd6);
        settle();
        checks++;
        if (ex_aluop !== 2'b10 || ex_alusrc !== 1'b0) begin
            errors++;
            $display("FAIL pass_ex: got aluop=%b alusrc=%b want 10/0", ex_aluop, ex_alusrc);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL pass_nostall: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (ex_alusrc !== 1'b1 || ex_aluop !== 2'b00 || mem_memread !== 1'b0 || wb_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL pass_edge2: got alusrc=%b aluop=%b memread=%b wb_rw=%b want 1/00/0/0",
                     ex_alusrc, ex_aluop, mem_memread, wb_regwrite);
        end
        tick();
        settle();
        checks++;
        if (wb_regwrite !== 1'b1 || wb_mem2reg !== 1'b0 || mem_memread !== 1'b1) begin
            errors++;
            $display("FAIL pass_edge3: got wb_rw=%b wb_m2r=%b memread=%b want 1/0/1",
                     wb_regwrite, wb_mem2reg, mem_memread);
        end
        tick();
        settle();
        checks++;
        if (wb_mem2reg !== 1'b1 || mem_memread !== 1'b0) begin
            errors++;
            $display("FAIL pass_edge4: got wb_m2r=%b memread=%b want 1/0", wb_mem2reg, mem_memread);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 1, 1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd1, 5'd3, 5'd8);
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall1: got %b want 1", stall);
        end
        tick();
        settle();
        checks++;
        if (ex_alusrc !== 1'b0 || ex_aluop !== 2'b00 || mem_memread !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: got alusrc=%b aluop=%b memread=%b want 0/00/1",
                     ex_alusrc, ex_aluop, mem_memread);
        end
`ifdef FORWARDING_EN
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall2: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_b !== 2'b01 || fwd_a !== 2'b00 || ex_aluop !== 2'b10) begin
            errors++;
            $display("FAIL lu_fwd: got fwd_a=%b fwd_b=%b aluop=%b want 00/01/10", fwd_a, fwd_b, ex_aluop);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall2: got %b want 1", stall);
        end
        tick();
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall3: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_b !== 2'b00 || ex_aluop !== 2'b10) begin
            errors++;
            $display("FAIL lu_fwd: got fwd_b=%b aluop=%b want 00/10", fwd_b, ex_aluop);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lu_cnt: got %0d want 2", stall_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd1, 5'd2, 5'd4);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd4, 5'd0, 5'd9);
        settle();
`ifdef FORWARDING_EN
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_fwd: got fwd_a=%b fwd_b=%b cnt=%0d want 10/00/0", fwd_a, fwd_b, stall_cnt);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall1: got %b want 1", stall);
        end
        tick();
        settle();
        checks++;
        if (stall !== 1'b1 || fwd_a !== 2'b00) begin
            errors++;
            $display("FAIL b2b_stall2: got stall=%b fwd_a=%b want 1/00", stall, fwd_a);
        end
        tick();
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall3: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b00 || ex_aluop !== 2'b10 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_final: got fwd_a=%b aluop=%b cnt=%0d want 00/10/2", fwd_a, ex_aluop, stall_cnt);
        end
`endif
    endtask

    task automatic test_double_fwd();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd7);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd7);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd7, 5'd0, 5'd10);
        settle();
`ifdef FORWARDING_EN
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL dbl_stall: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL dbl_fwd: got fwd_a=%b fwd_b=%b want 10/00", fwd_a, fwd_b);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL dbl_stall: got %b want 1", stall);
        end
        tick();
        tick();
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b00 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL dbl_fwd: got fwd_a=%b cnt=%0d want 00/2", fwd_a, stall_cnt);
        end
`endif
    endtask

    task automatic test_x0();
        do_reset();
        drive(0, 1, 1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd1);
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: got %b want 0", stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_fwd: got fwd_a=%b fwd_b=%b stall=%b want 00/00/0", fwd_a, fwd_b, stall);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive(1, 1, 0, 0, 0, 1, 2'b01, 5'd1, 5'd2, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd1, 5'd3, 5'd8);
        ex_zero = 1'b0;
        settle();
        checks++;
        if (pc_src !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL br_nottaken: got pc_src=%b stall=%b want 0/1", pc_src, stall);
        end
        ex_zero = 1'b1;
        #1;
        checks++;
        if (pc_src !== 1'b1 || if_flush !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL br_taken: got pc_src=%b if_flush=%b stall=%b want 1/1/0", pc_src, if_flush, stall);
        end
        tick();
        nop();
        settle();
        checks++;
        if (ex_branch !== 1'b0 || ex_aluop !== 2'b00 || pc_src !== 1'b0 || mem_memread !== 1'b1) begin
            errors++;
            $display("FAIL br_after: got br=%b aluop=%b pc_src=%b memread=%b want 0/00/0/1",
                     ex_branch, ex_aluop, pc_src, mem_memread);
        end
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL br_cnt: got flush=%0d stall_cnt=%0d stall=%b want 1/0/0", flush_cnt, stall_cnt, stall);
        end
        ex_zero = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(0, 1, 1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0, 1, 2'b10, 5'd1, 5'd3, 5'd8);
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b want 1", stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checks++;
        if (ex_alusrc !== 1'b0 || mem_memread !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: got alusrc=%b memread=%b stall=%b cnt=%0d want 0/0/0/0",
                     ex_alusrc, mem_memread, stall, stall_cnt);
        end
        nop();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 0, 1, 1, 2'b00, 5'd0, 5'd0, 5'd4);
            tick();
            drive(0, 0, 0, 0, 0, 0, 2'b00, 5'd4, 5'd0, 5'd0);
            tick();
            tick();
            tick();
        end
        nop();
        settle();
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt4: got %0d want 15", s_stall_cnt);
        end
        checks++;
`ifdef FORWARDING_EN
        if (stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d want 20", stall_cnt);
        end
`else
        if (stall_cnt !== 16'd40) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d want 40", stall_cnt);
        end
`endif
        checks++;
        if (s_flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_flush4: got %0d want 0", s_flush_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        ex_zero = 1'b0;
        nop();
        test_reset();
        test_pass_through();
        test_load_use();
        test_back_to_back();
        test_double_fwd();
        test_x0();
        test_branch();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
